// File: rtl/operand_capture_fsm.sv
// Purpose : assembles NUM_OPERANDS operands of NUM_DIGITS digits each from a strobed digit stream.
// Latency : a digit is visible in operands 1 cycle after its strobe; ops_valid rises 1 cycle after the final digit.
// Backpress: while ops_valid is high and ops_ready is low the set is held frozen and further digits are ignored.
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   digit_in      digit value, sampled only while digit_valid=1
//   digit_valid   one-cycle digit strobe
//   clear_in      synchronous clear of the capture round; beats digits and the handshake
//   ops_ready     downstream accepts the operand set
//   operands      operand k at [(k+1)*OW-1 : k*OW]
//   ops_valid     operand set complete and stable
//   op_idx        operand currently being filled
//   dig_cnt       digits accepted into the current operand
//   digit_err     one-cycle pulse after a rejected (out of range) digit
//
// Build option: define GRAY_DECODE_EN to treat digit_in as Gray code (decoded before range check).

module operand_capture_fsm #(
  parameter int DIGIT_W      = 4,
  parameter int NUM_DIGITS   = 3,
  parameter int NUM_OPERANDS = 2,
  parameter int MAX_DIGIT    = 9,
  localparam int OW = NUM_DIGITS * DIGIT_W,
  localparam int IW = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1,
  localparam int CW = $clog2(NUM_DIGITS + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DIGIT_W-1:0]         digit_in,
  input  logic                       digit_valid,
  input  logic                       clear_in,
  input  logic                       ops_ready,
  output logic [NUM_OPERANDS*OW-1:0] operands,
  output logic                       ops_valid,
  output logic [IW-1:0]              op_idx,
  output logic [CW-1:0]              dig_cnt,
  output logic                       digit_err
);

  typedef enum logic {
    S_CAPTURE = 1'b0,
    S_HOLD    = 1'b1
  } state_t;

  localparam logic [CW-1:0] LAST_DIG = CW'(NUM_DIGITS - 1);
  localparam logic [IW-1:0] LAST_OP  = IW'(NUM_OPERANDS - 1);

  state_t                             state_q, state_d;
  logic [NUM_OPERANDS-1:0][OW-1:0]    ops_q, ops_d;
  logic [IW-1:0]                      idx_q, idx_d;
  logic [CW-1:0]                      cnt_q, cnt_d;
  logic                               err_q, err_d;

  logic [DIGIT_W-1:0]                 dec;
  logic                               legal;

  // Digit decode ahead of the range check.
  always_comb begin
    dec = '0;
`ifdef GRAY_DECODE_EN
    // Binary bit i is the XOR of all Gray bits at or above i.
    for (int i = 0; i < DIGIT_W; i++) begin
      dec[i] = ^(digit_in >> i);
    end
`else
    dec = digit_in;
`endif
  end

  // Compare in 32 bits so a MAX_DIGIT at or above 2**DIGIT_W simply accepts everything.
  assign legal = (32'(dec) <= 32'(MAX_DIGIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_CAPTURE;
      ops_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ops_q   <= ops_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ops_d   = ops_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;

    if (clear_in) begin
      // Clear wins over a concurrent digit (dropped silently) and a concurrent handshake.
      state_d = S_CAPTURE;
      ops_d   = '0;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_CAPTURE: begin
          if (digit_valid) begin
            if (legal) begin
              // Most significant digit arrives first, so shift left and append.
              ops_d[idx_q] = (ops_q[idx_q] << DIGIT_W) | OW'(dec);
              if (cnt_q == LAST_DIG) begin
                cnt_d = '0;
                if (idx_q == LAST_OP) begin
                  idx_d   = '0;
                  state_d = S_HOLD;
                end else begin
                  idx_d = idx_q + IW'(1);
                end
              end else begin
                cnt_d = cnt_q + CW'(1);
              end
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (ops_ready) begin
            state_d = S_CAPTURE;
          end
        end
        default: state_d = S_CAPTURE;
      endcase
    end
  end

  assign operands  = ops_q;
  assign ops_valid = (state_q == S_HOLD);
  assign op_idx    = idx_q;
  assign dig_cnt   = cnt_q;
  assign digit_err = err_q;

endmodule
